// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: run-state encoding, instruction
// step sizes and the redirect-source enumeration used by the fetch-address selector.
package pc_sequencer_pkg;

    typedef enum logic {
        STATE_HALT    = 1'b0,
        STATE_EXECUTE = 1'b1
    } state_t;

    localparam int INC_COMPRESSED = 2;
    localparam int INC_NORMAL     = 4;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_TRAP = 3'd1,
        SRC_RET  = 3'd2,
        SRC_JUMP = 3'd3,
        SRC_SEQ  = 3'd4
    } redirect_src_t;

    function automatic logic is_redirect(input redirect_src_t src);
        return (src == SRC_TRAP) || (src == SRC_RET) || (src == SRC_JUMP);
    endfunction

endpackage

// File: rtl/pc_sequencer_stage_pipe.sv
// PC/valid shift register carrying fetch addresses from stage 0 down to execute.
// A flush kills every stage except the oldest one after the shift.
module pc_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     shift,
    input  logic                     flush,
    input  logic [XLEN-1:0]          in_pc,
    output logic [STAGES*XLEN-1:0]   stage_pc,
    output logic [STAGES-1:0]        stage_valid
);

    logic [XLEN-1:0]   pc_q [STAGES];
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_next;

    always_comb begin
        valid_next = valid_q;
        if (shift) begin
            valid_next = {valid_q[STAGES-2:0], 1'b1};
        end
        if (flush) begin
            valid_next[STAGES-2:0] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                pc_q[k] <= '0;
            end
            valid_q <= '0;
        end else begin
            if (shift) begin
                pc_q[0] <= in_pc;
                for (int k = 1; k < STAGES; k++) begin
                    pc_q[k] <= pc_q[k-1];
                end
            end
            valid_q <= valid_next;
        end
    end

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_flat
            assign stage_pc[g*XLEN +: XLEN] = pc_q[g];
        end
    endgenerate

    assign stage_valid = valid_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch address selection, PC pipeline and alignment faults.
// Define PC_COMPRESSED_EN for 16-bit instruction support (2-byte steps, bit-0 alignment).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              STAGES     = 2,
    parameter logic [XLEN-1:0] RESET_ADDR = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mgmt_set,
    input  logic                     mgmt_jump,
    input  logic [XLEN-1:0]          mgmt_data,
    input  logic                     run,
    input  logic                     progress,
    input  logic                     step,
    input  logic                     stall,
    input  logic                     trap,
    input  logic                     ret,
    input  logic                     jump_en,
    input  logic [XLEN-1:0]          trap_vector,
    input  logic [XLEN-1:0]          ret_vector,
    input  logic [XLEN-1:0]          jump_target,
    input  logic                     fetch_compressed,
    output logic [XLEN-1:0]          fetch_pc,
    output logic [XLEN-1:0]          next_fetch_pc,
    output logic                     step_pc,
    output logic [STAGES*XLEN-1:0]   stage_pc,
    output logic [STAGES-1:0]        stage_valid,
    output logic [XLEN-1:0]          execute_pc,
    output logic                     misaligned_fault,
    output logic [XLEN-1:0]          misaligned_addr
);

`ifdef PC_COMPRESSED_EN
    localparam bit COMPRESSED_EN = 1'b1;
`else
    localparam bit COMPRESSED_EN = 1'b0;
`endif
    localparam int ALIGN_BIT = COMPRESSED_EN ? 0 : 1;

    state_t          state;
    redirect_src_t   src;
    logic            bad_target;
    logic [XLEN-1:0] bad_addr;
    logic [XLEN-1:0] inc;
    logic            shift;
    logic            flush;

    // fetch_compressed only affects the step size when compressed support is built in
    assign inc = (COMPRESSED_EN && fetch_compressed) ? XLEN'(INC_COMPRESSED)
                                                     : XLEN'(INC_NORMAL);

    // The run input is the state; there is no internal transition logic.
    always_comb begin
        state = run ? STATE_EXECUTE : STATE_HALT;
    end

    always_comb begin
        src        = SRC_NONE;
        bad_target = 1'b0;
        bad_addr   = '0;
        if (rst_n && (state == STATE_EXECUTE)) begin
            if (trap) begin
                src = SRC_TRAP;
            end else if (ret) begin
                if (ret_vector[ALIGN_BIT]) begin
                    bad_target = 1'b1;
                    bad_addr   = ret_vector;
                end else begin
                    src = SRC_RET;
                end
            end else if (jump_en) begin
                if (jump_target[ALIGN_BIT]) begin
                    bad_target = 1'b1;
                    bad_addr   = jump_target;
                end else begin
                    src = SRC_JUMP;
                end
            end else if (!stall) begin
                src = SRC_SEQ;
            end
        end
    end

    always_comb begin
        next_fetch_pc = fetch_pc;
        step_pc       = 1'b0;
        if (!rst_n) begin
            next_fetch_pc = RESET_ADDR;
        end else begin
            case (src)
                SRC_TRAP: begin next_fetch_pc = trap_vector;     step_pc = 1'b1; end
                SRC_RET:  begin next_fetch_pc = ret_vector;      step_pc = 1'b1; end
                SRC_JUMP: begin next_fetch_pc = jump_target;     step_pc = 1'b1; end
                SRC_SEQ:  begin next_fetch_pc = fetch_pc + inc;  step_pc = 1'b1; end
                default:  begin next_fetch_pc = fetch_pc;        step_pc = 1'b0; end
            endcase
        end
    end

    assign shift = step && !stall && (state == STATE_EXECUTE);
    assign flush = step && is_redirect(src);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc         <= RESET_ADDR;
            misaligned_fault <= 1'b0;
            misaligned_addr  <= '0;
        end else begin
            if (state == STATE_HALT) begin
                if (!progress) begin
                    if (mgmt_set) begin
                        fetch_pc <= mgmt_data;
                    end else if (mgmt_jump) begin
                        fetch_pc <= execute_pc + mgmt_data;
                    end
                end
            end else if (step && step_pc) begin
                fetch_pc <= next_fetch_pc;
            end
            misaligned_fault <= step && bad_target;
            if (step && bad_target) begin
                misaligned_addr <= bad_addr;
            end
        end
    end

    pc_stage_pipe #(
        .XLEN   (XLEN),
        .STAGES (STAGES)
    ) u_stage_pipe (
        .clk         (clk),
        .rst_n       (rst_n),
        .shift       (shift),
        .flush       (flush),
        .in_pc       (fetch_pc),
        .stage_pc    (stage_pc),
        .stage_valid (stage_valid)
    );

    assign execute_pc = stage_pc[STAGES*XLEN-1 -: XLEN];

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (XLEN=32, STAGES=2, RESET_ADDR=0x100) with an
// expectation queue; follows PC_COMPRESSED_EN if it is defined for the build.
module tb_pc_sequencer;

    localparam int XLEN   = 32;
    localparam int STAGES = 2;

`ifdef PC_COMPRESSED_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   mgmt_set, mgmt_jump;
    logic [XLEN-1:0]        mgmt_data;
    logic                   run, progress, step, stall;
    logic                   trap, ret, jump_en;
    logic [XLEN-1:0]        trap_vector, ret_vector, jump_target;
    logic                   fetch_compressed;
    logic [XLEN-1:0]        fetch_pc, next_fetch_pc, execute_pc, misaligned_addr;
    logic                   step_pc, misaligned_fault;
    logic [STAGES*XLEN-1:0] stage_pc;
    logic [STAGES-1:0]      stage_valid;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .XLEN       (XLEN),
        .STAGES     (STAGES),
        .RESET_ADDR (32'h100)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mgmt_set         (mgmt_set),
        .mgmt_jump        (mgmt_jump),
        .mgmt_data        (mgmt_data),
        .run              (run),
        .progress         (progress),
        .step             (step),
        .stall            (stall),
        .trap             (trap),
        .ret              (ret),
        .jump_en          (jump_en),
        .trap_vector      (trap_vector),
        .ret_vector       (ret_vector),
        .jump_target      (jump_target),
        .fetch_compressed (fetch_compressed),
        .fetch_pc         (fetch_pc),
        .next_fetch_pc    (next_fetch_pc),
        .step_pc          (step_pc),
        .stage_pc         (stage_pc),
        .stage_valid      (stage_valid),
        .execute_pc       (execute_pc),
        .misaligned_fault (misaligned_fault),
        .misaligned_addr  (misaligned_addr)
    );

    task automatic expect_val(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [63:0] obs);
        exp_t e;
        n_asserts++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b1; step = 1'b1; progress = 1'b0; stall = 1'b0;
        mgmt_set = 1'b0; mgmt_jump = 1'b0; mgmt_data = '0;
        trap = 1'b1; trap_vector = 32'h80; ret = 1'b0; ret_vector = '0;
        jump_en = 1'b0; jump_target = '0; fetch_compressed = 1'b0;
        repeat (2) tick();

        // reset state, with a trap pending that must not leak through
        expect_val("rst_fetch_pc", 64'h100);
        expect_val("rst_stage_valid", 64'h0);
        expect_val("rst_stage_pc", 64'h0);
        expect_val("rst_next_fetch_pc", 64'h100);
        expect_val("rst_step_pc", 64'h0);
        expect_val("rst_fault", 64'h0);
        expect_val("rst_addr", 64'h0);
        check(fetch_pc); check(stage_valid); check(stage_pc);
        check(next_fetch_pc); check(step_pc); check(misaligned_fault); check(misaligned_addr);

        trap = 1'b0; rst_n = 1'b1; #1;
        expect_val("rel_next", 64'h104); expect_val("rel_step_pc", 64'h1);
        check(next_fetch_pc); check(step_pc);
        tick();
        expect_val("seq1_fetch", 64'h104); expect_val("seq1_valid", 64'h1);
        check(fetch_pc); check(stage_valid);
        tick();
        expect_val("seq2_fetch", 64'h108); expect_val("seq2_exec", 64'h100);
        expect_val("seq2_valid", 64'h3);
        check(fetch_pc); check(execute_pc); check(stage_valid);

        // stall holds everything
        stall = 1'b1; #1;
        expect_val("stall_step_pc", 64'h0); expect_val("stall_next", 64'h108);
        check(step_pc); check(next_fetch_pc);
        tick();
        expect_val("stall_fetch", 64'h108);
        expect_val("stall_stages", 64'h00000100_00000104);
        expect_val("stall_valid", 64'h3);
        check(fetch_pc); check(stage_pc); check(stage_valid);
        stall = 1'b0;

        // trap beats a simultaneous (misaligned-irrelevant) jump
        trap = 1'b1; trap_vector = 32'h80; jump_en = 1'b1; jump_target = 32'h2000; #1;
        expect_val("race_next", 64'h80); expect_val("race_step_pc", 64'h1);
        check(next_fetch_pc); check(step_pc);
        tick();
        expect_val("race_fetch", 64'h80); expect_val("race_valid", 64'h2);
        expect_val("race_fault", 64'h0);
        check(fetch_pc); check(stage_valid); check(misaligned_fault);
        trap = 1'b0; jump_en = 1'b0;
        tick();
        expect_val("post_trap_fetch", 64'h84); expect_val("post_trap_exec", 64'h108);
        expect_val("post_trap_valid", 64'h1);
        check(fetch_pc); check(execute_pc); check(stage_valid);

        // ret beats jump
        ret = 1'b1; ret_vector = 32'h300; jump_en = 1'b1; jump_target = 32'h500; #1;
        expect_val("ret_next", 64'h300);
        check(next_fetch_pc);
        tick();
        expect_val("ret_fetch", 64'h300); expect_val("ret_valid", 64'h2);
        expect_val("ret_exec", 64'h80);
        check(fetch_pc); check(stage_valid); check(execute_pc);
        ret = 1'b0;

        // jump to 0x1002: faults without compressed support, accepted with it
        jump_target = 32'h1002; #1;
        expect_val("mis_step_pc", CE ? 64'h1 : 64'h0);
        expect_val("mis_next", CE ? 64'h1002 : 64'h300);
        check(step_pc); check(next_fetch_pc);
        tick();
        expect_val("mis_fetch", CE ? 64'h1002 : 64'h300);
        expect_val("mis_fault", CE ? 64'h0 : 64'h1);
        expect_val("mis_addr", CE ? 64'h0 : 64'h1002);
        expect_val("mis_valid", CE ? 64'h0 : 64'h1);
        check(fetch_pc); check(misaligned_fault); check(misaligned_addr); check(stage_valid);
        jump_en = 1'b0; step = 1'b0;
        tick();
        expect_val("nostep_fault", 64'h0);
        expect_val("nostep_fetch", CE ? 64'h1002 : 64'h300);
        expect_val("nostep_stages", 64'h00000084_00000300);
        check(misaligned_fault); check(fetch_pc); check(stage_pc);
        step = 1'b1;

        // management writes in HALT
        run = 1'b0; mgmt_set = 1'b1; mgmt_data = 32'h40; #1;
        expect_val("halt_step_pc", 64'h0);
        check(step_pc);
        tick();
        expect_val("mset_fetch", 64'h40);
        check(fetch_pc);
        mgmt_set = 1'b0; run = 1'b1;
        repeat (2) tick();
        expect_val("mrun_exec", 64'h40); expect_val("mrun_fetch", 64'h48);
        check(execute_pc); check(fetch_pc);
        run = 1'b0; mgmt_jump = 1'b1; mgmt_data = 32'hFFFF_FFFC; #1;
        expect_val("halt_next", 64'h48);
        check(next_fetch_pc);
        tick();
        expect_val("mjump_fetch", 64'h3C); expect_val("mjump_exec", 64'h40);
        check(fetch_pc); check(execute_pc);
        mgmt_set = 1'b1; mgmt_data = 32'h200;
        tick();
        expect_val("mboth_fetch", 64'h200);
        check(fetch_pc);
        progress = 1'b1; mgmt_data = 32'h999;
        tick();
        expect_val("mprog_fetch", 64'h200);
        check(fetch_pc);
        mgmt_set = 1'b0; mgmt_jump = 1'b0; progress = 1'b0;

        // compressed step
        run = 1'b1; fetch_compressed = 1'b1;
        tick();
        expect_val("cstep_fetch", CE ? 64'h202 : 64'h204);
        check(fetch_pc);
        fetch_compressed = 1'b0;

        // misaligned ret faults in both builds; trap vector is never checked
        ret = 1'b1; ret_vector = 32'h3; #1;
        expect_val("mret_step_pc", 64'h0);
        check(step_pc);
        tick();
        expect_val("mret_fault", 64'h1); expect_val("mret_addr", 64'h3);
        expect_val("mret_fetch", CE ? 64'h202 : 64'h204);
        check(misaligned_fault); check(misaligned_addr); check(fetch_pc);
        ret = 1'b0; trap = 1'b1; trap_vector = 32'h1003;
        tick();
        expect_val("mtrap_fetch", 64'h1003); expect_val("mtrap_fault", 64'h0);
        expect_val("mtrap_addr", 64'h3);
        check(fetch_pc); check(misaligned_fault); check(misaligned_addr);

        // asynchronous reset mid-operation
        trap_vector = 32'h80; rst_n = 1'b0; #1;
        expect_val("arst_fetch", 64'h100); expect_val("arst_valid", 64'h0);
        expect_val("arst_stages", 64'h0); expect_val("arst_addr", 64'h0);
        expect_val("arst_next", 64'h100); expect_val("arst_step_pc", 64'h0);
        check(fetch_pc); check(stage_valid); check(stage_pc);
        check(misaligned_addr); check(next_fetch_pc); check(step_pc);
        tick();
        expect_val("arst_hold_fetch", 64'h100);
        check(fetch_pc);
        trap = 1'b0; run = 1'b0; rst_n = 1'b1;

        // sequential wrap modulo 2^XLEN
        mgmt_set = 1'b1; mgmt_data = 32'hFFFF_FFFC;
        tick();
        mgmt_set = 1'b0; run = 1'b1; #1;
        expect_val("wrap_next", 64'h0);
        check(next_fetch_pc);
        tick();
        expect_val("wrap_fetch", 64'h0);
        check(fetch_pc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
